// File: rtl/proc_pkg.sv
// Shared datapath widths, control-word layout and ALU op encodings for the
// ID/EX pipeline slice.
package proc_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 9;

  // Bit index of mem_read inside the control word; must match ctrl_t below.
  localparam int unsigned CTRL_MEM_READ = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, WB bypass, pipeline control and EX-side outputs of the
// ID->EX register, grouped as one bundle.
interface id_ex_stage_if #(
  parameter int unsigned N      = proc_pkg::N,
  parameter int unsigned REG_AW = proc_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CTRL_W = proc_pkg::CTRL_W;

  logic              id_valid;
  logic [N-1:0]      id_pc;
  logic [N-1:0]      id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [N-1:0]      id_rdata1;
  logic [N-1:0]      id_rdata2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [N-1:0]      wb_data;
  logic              flush;
  logic              ex_stall;
  logic              id_stall;
  logic              ex_valid;
  logic [N-1:0]      ex_pc;
  logic [N-1:0]      ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [N-1:0]      ex_op_a;
  logic [N-1:0]      ex_op_b;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
           id_ctrl, wb_reg_write, wb_rd, wb_data, flush, ex_stall,
    input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op_a, ex_op_b, ex_ctrl, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
           id_ctrl, wb_reg_write, wb_rd, wb_data, flush, ex_stall,
    output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op_a, ex_op_b, ex_ctrl, bubble_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: ID consumes a register that the load in EX has
// not produced yet.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB->ID bypass, load-use stall/bubble insertion
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned N      = proc_pkg::N,
  parameter int unsigned REG_AW = proc_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  localparam int unsigned CTRL_W = proc_pkg::CTRL_W;

  logic              ex_valid;
  logic [N-1:0]      ex_pc;
  logic [N-1:0]      ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [N-1:0]      ex_op_a;
  logic [N-1:0]      ex_op_b;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_count;

  logic              hazard;
  logic              wb_live;
  logic [N-1:0]      op_a;
  logic [N-1:0]      op_b;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[proc_pkg::CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign bus.id_stall = hazard | bus.ex_stall;
  assign wb_live      = bus.wb_reg_write && (bus.wb_rd != '0);

  always_comb begin
    op_a = bus.id_rdata1;
    if (bus.id_rs1 == '0)
      op_a = '0;
    else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs1))
      op_a = bus.wb_data;
  end

  always_comb begin
    op_b = bus.id_rdata2;
    if (bus.id_rs2 == '0)
      op_b = '0;
    else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs2))
      op_b = bus.wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_ctrl      <= '0;
      bubble_count <= '0;
    end else if (bus.flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (bus.ex_stall) begin
      // A held instruction must still see results retiring underneath it.
      if (ex_valid && wb_live && (bus.wb_rd == ex_rs1))
        ex_op_a <= bus.wb_data;
      if (ex_valid && wb_live && (bus.wb_rd == ex_rs2))
        ex_op_b <= bus.wb_data;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      ex_valid <= bus.id_valid;
      ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
      ex_pc    <= bus.id_pc;
      ex_imm   <= bus.id_imm;
      ex_rs1   <= bus.id_rs1;
      ex_rs2   <= bus.id_rs2;
      ex_rd    <= bus.id_rd;
      ex_op_a  <= op_a;
      ex_op_b  <= op_b;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_pc        = ex_pc;
  assign bus.ex_imm       = ex_imm;
  assign bus.ex_rs1       = ex_rs1;
  assign bus.ex_rs2       = ex_rs2;
  assign bus.ex_rd        = ex_rd;
  assign bus.ex_op_a      = ex_op_a;
  assign bus.ex_op_b      = ex_op_b;
  assign bus.ex_ctrl      = ex_ctrl;
  assign bus.bubble_count = bubble_count;

endmodule
